// File: rtl/div_sched_ctrl.sv
// div_sched_ctrl: programmable clock divider with a glitch-free ratio scheduler.
//
// The block divides clk by a run-time ratio N (2..2^WIDTH-1). clk_div is high
// for ceil(N/2) cycles and low for the rest, and tick marks the last cycle of
// every period. A new ratio taken while running is held in a pending register
// and only applied at the end of the current period, so no clk_div phase is
// ever shortened or stretched.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous reset, active HIGH (1 = reset)
//   enable     - run request, sampled in IDLE and at the end of each period
//   cfg_valid  - ratio offer on cfg_ratio
//   cfg_ratio  - requested divide ratio N
//   cfg_ready  - ratio can be accepted this cycle (low while one is pending)
//   clk_div    - divided clock, registered
//   tick       - one-cycle pulse in the last cycle of each period
//   busy       - state is RUN or PEND
//   cfg_err    - one-cycle pulse after an accepted ratio below 2 was rejected
//   cur_ratio  - ratio currently in effect
//   dbg_state  - FSM state (0 IDLE, 1 RUN, 2 PEND) for observation
//
// Handshake: an offer transfers on a rising edge where cfg_valid and
// cfg_ready are both 1; cfg_valid may be held without transfer while
// cfg_ready is 0, and the offer is consumed once it transfers.
module div_sched_ctrl #(
  parameter int WIDTH         = 16,
  parameter int DEFAULT_RATIO = 46
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_ratio,
  output logic             cfg_ready,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic             cfg_err,
  output logic [WIDTH-1:0] cur_ratio,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] DEF_RATIO = WIDTH'(DEFAULT_RATIO);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
  localparam logic [WIDTH:0]   ONE_X     = (WIDTH + 1)'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;

  logic             xfer;
  logic             legal;
  logic             wrap;
  logic             run_d;
  logic [WIDTH:0]   half_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;

    xfer  = cfg_valid && cfg_ready_q;
    legal = (cfg_ratio >= TWO);
    // ratio_q is always >= 2, so ratio_q - 1 cannot underflow.
    wrap  = (count_q == (ratio_q - ONE));

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        // A ratio offered together with enable is in effect from count 0.
        if (xfer && legal) ratio_d = cfg_ratio;
        if (enable) state_d = RUN;
      end
      RUN: begin
        count_d = wrap ? '0 : (count_q + ONE);
        if (wrap && !enable) begin
          // Stopping: an offer taken in this last cycle goes straight to
          // cur_ratio since there is no following period to defer it to.
          state_d = IDLE;
          if (xfer && legal) ratio_d = cfg_ratio;
        end else if (xfer && legal) begin
          // Even if taken in the wrap cycle, it waits for the next wrap.
          pend_d  = cfg_ratio;
          state_d = PEND;
        end
      end
      PEND: begin
        count_d = wrap ? '0 : (count_q + ONE);
        if (wrap) begin
          ratio_d = pend_q;
          state_d = enable ? RUN : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Outputs are registered, so they are derived from the next-cycle values.
    // half is one bit wider so that N = 2^WIDTH-1 does not overflow.
    run_d       = (state_d != IDLE);
    half_d      = ({1'b0, ratio_d} + ONE_X) >> 1;
    clk_div_d   = run_d && ({1'b0, count_d} < half_d);
    tick_d      = run_d && (count_d == (ratio_d - ONE));
    busy_d      = run_d;
    cfg_ready_d = (state_d != PEND);
    cfg_err_d   = xfer && !legal;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ratio_q     <= DEF_RATIO;
      pend_q      <= '0;
      clk_div_q   <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ratio_q     <= ratio_d;
      pend_q      <= pend_d;
      clk_div_q   <= clk_div_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign clk_div   = clk_div_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign cur_ratio = ratio_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Bench for div_sched_ctrl. Stimulus pushes the expected shape of every
// period that must complete ({high cycles, period length}) and the expected
// cur_ratio for every rejected offer; a monitor measures the DUT on the
// falling edge and pops/compares on each tick and cfg_err pulse.
module tb_div_sched_ctrl;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_ratio;
  logic         cfg_ready;
  logic         clk_div;
  logic         tick;
  logic         busy;
  logic         cfg_err;
  logic [W-1:0] cur_ratio;
  logic [1:0]   dbg_state;

  logic [31:0]  exp_q[$];
  logic [W-1:0] err_q[$];

  int checks = 0;
  int errors = 0;

  div_sched_ctrl #(.WIDTH(W), .DEFAULT_RATIO(46)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ratio (cfg_ratio),
    .cfg_ready (cfg_ready),
    .clk_div   (clk_div),
    .tick      (tick),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .cur_ratio (cur_ratio),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    cfg_valid = 1'b0;
    rst_n     = 1'b1;
    cyc(1);
    rst_n     = 1'b0;
  endtask

  task automatic offer(input logic [W-1:0] r);
    cfg_valid = 1'b1;
    cfg_ratio = r;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic push_per(input int high, input int len, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({high[15:0], len[15:0]});
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    int high_cnt;
    int len_cnt;
    bit fell;
    bit glitch;
    logic [31:0] e;
    logic [W-1:0] er;
    high_cnt = 0; len_cnt = 0; fell = 0; glitch = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        high_cnt = 0; len_cnt = 0; fell = 0; glitch = 0;
      end else begin
        if (busy) begin
          len_cnt++;
          if (clk_div) begin
            high_cnt++;
            if (fell) glitch = 1;
          end else begin
            fell = 1;
          end
        end
        if (tick) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_tick: high %0d len %0d, none expected", high_cnt, len_cnt);
          end else begin
            e = exp_q.pop_front();
            chk("period_high", high_cnt, {16'd0, e[31:16]});
            chk("period_len", len_cnt, {16'd0, e[15:0]});
            chk("period_no_glitch", {31'd0, glitch}, 32'd0);
          end
          high_cnt = 0; len_cnt = 0; fell = 0; glitch = 0;
        end
        if (cfg_err) begin
          if (err_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cfg_err: cur_ratio %0d, none expected", cur_ratio);
          end else begin
            er = err_q.pop_front();
            chk("err_cur_ratio", {16'd0, cur_ratio}, {16'd0, er});
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0;
    cyc(3);
    rst_n = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_clk_div", clk_div, 0);
    chk("rst_tick", tick, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cur_ratio", cur_ratio, 46);
    chk("rst_state", dbg_state, 0);

    // A: default ratio, then 10 offered at count 5 of the second period.
    push_per(23, 46, 2);
    push_per(5, 10, 3);
    enable = 1'b1;
    cyc(1);                      // count 0
    chk("a_busy", busy, 1);
    chk("a_clk_div_start", clk_div, 1);
    cyc(51);                     // period 2, count 5
    offer(16'd10);               // count 6
    chk("a_ready_pend", cfg_ready, 0);
    chk("a_ratio_hold", cur_ratio, 46);
    chk("a_state_pend", dbg_state, 2);
    cyc(39);                     // count 45 (wrap cycle)
    chk("a_ready_wrap", cfg_ready, 0);
    cyc(1);                      // new period at N=10
    chk("a_ready_back", cfg_ready, 1);
    chk("a_ratio_new", cur_ratio, 10);
    cyc(30);                     // start of 4th 10-cycle period
    do_reset();
    chk("a_drained", exp_q.size(), 0);

    // B: illegal offers in IDLE and in RUN.
    err_q.push_back(16'd46);
    offer(16'd1);
    err_q.push_back(16'd46);
    offer(16'd0);
    cyc(1);
    chk("b_idle_state", dbg_state, 0);
    chk("b_idle_ratio", cur_ratio, 46);
    offer(16'd6);
    chk("b_legal_idle", cur_ratio, 6);
    push_per(3, 6, 3);
    enable = 1'b1;
    cyc(1);                      // count 0
    cyc(2);                      // count 2
    err_q.push_back(16'd6);
    offer(16'd1);                // count 3
    chk("b_run_ready", cfg_ready, 1);
    err_q.push_back(16'd6);
    offer(16'd0);                // count 4
    chk("b_run_state", dbg_state, 1);
    cyc(14);                     // count 0 of 4th period
    do_reset();
    chk("b_drained", exp_q.size(), 0);
    chk("b_err_drained", err_q.size(), 0);

    // C: N=5 with stop at count 1, then a drop/restore within a period.
    push_per(3, 5, 1);
    cfg_valid = 1'b1; cfg_ratio = 16'd5; enable = 1'b1;
    cyc(1);                      // count 0 at N=5
    cfg_valid = 1'b0;
    chk("c_ratio_same_cycle", cur_ratio, 5);
    cyc(1);                      // count 1
    enable = 1'b0;
    cyc(3);                      // count 4
    chk("c_still_busy", busy, 1);
    cyc(1);
    chk("c_stop_busy", busy, 0);
    chk("c_stop_clk_div", clk_div, 0);
    chk("c_stop_state", dbg_state, 0);
    push_per(3, 5, 4);
    enable = 1'b1;
    cyc(1);                      // count 0
    cyc(1);                      // count 1
    enable = 1'b0;
    cyc(1);                      // count 2
    enable = 1'b1;
    cyc(13);                     // count 0 of 4th period
    chk("c_no_stop", busy, 1);
    enable = 1'b0;
    cyc(5);
    chk("c_stop2_busy", busy, 0);
    chk("c_drained", exp_q.size(), 0);

    // D: 7 offered in the wrap cycle at N=4, then reset while pending.
    offer(16'd4);
    push_per(2, 4, 2);
    push_per(4, 7, 2);
    enable = 1'b1;
    cyc(1);                      // count 0
    cyc(3);                      // count 3 (wrap)
    offer(16'd7);                // next period count 0
    chk("d_ready_pend", cfg_ready, 0);
    chk("d_ratio_hold", cur_ratio, 4);
    cyc(4);                      // first period at N=7
    chk("d_ratio_new", cur_ratio, 7);
    cyc(14);                     // count 0 of 3rd 7-period
    offer(16'd9);                // count 1, pending
    chk("d_pend_again", dbg_state, 2);
    cyc(2);
    do_reset();
    chk("d_rst_ratio", cur_ratio, 46);
    chk("d_rst_state", dbg_state, 0);
    chk("d_rst_ready", cfg_ready, 1);
    cyc(2);
    chk("d_drained", exp_q.size(), 0);

    // E: N=3 sustained, then N=2 sustained.
    offer(16'd3);
    push_per(2, 3, 5);
    push_per(1, 2, 4);
    enable = 1'b1;
    cyc(1);                      // count 0
    cyc(12);                     // count 0 of 5th period
    offer(16'd2);                // count 1
    cyc(2);                      // count 0 at N=2
    chk("e_ratio2", cur_ratio, 2);
    cyc(6);
    enable = 1'b0;
    cyc(2);
    chk("e_stop_busy", busy, 0);
    cyc(2);
    chk("e_drained", exp_q.size(), 0);
    chk("e_err_drained", err_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
